tape_rec: RTL and testbench

//  Cassette recorder. Decodes the MSX 1200-baud FSK tape-out bit (PPI port C bit 5) into bytes and

---
 rtl/tape_rec.sv | 276 +++++++++++++++++++++++++++
 tb/tb_tape_rec.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tape_rec.sv
// Cassette recorder: decodes the MSX 1200-baud FSK tape-out bit into bytes and
// streams them, with .CAS block headers, into the DDRAM tape buffer.
module tape_rec #(
    parameter int MIN_PULSE = 400,
    parameter int THRESH    = 1678,
    parameter int MAX_PULSE = 4000,
    parameter int HDR_MIN   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_5m3,
    input  logic        cas_motor,
    input  logic        cas_in,
    input  logic        rewind,
    output logic [26:0] ram_a,
    output logic [7:0]  ram_do,
    output logic        ram_wr,
    input  logic        buff_mem_ready,
    output logic        overflow,
    output logic        recording
);

    localparam int CW = $clog2(MAX_PULSE + 1);
    localparam int HW = $clog2(HDR_MIN + 1);
    localparam logic [CW-1:0] MIN_W    = CW'(MIN_PULSE);
    localparam logic [CW-1:0] THR_W    = CW'(THRESH);
    localparam logic [CW-1:0] MAX_W    = CW'(MAX_PULSE);
    localparam logic [HW-1:0] HDR_LAST = HW'(HDR_MIN - 1);

    typedef enum logic [2:0] {
        IDLE,
        PAD,
        HDR,
        WAIT_START,
        DATA,
        STOP
    } state_t;

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    hdr_byte = 8'h1F;
            3'd1:    hdr_byte = 8'hA6;
            3'd2:    hdr_byte = 8'hDE;
            3'd3:    hdr_byte = 8'hBA;
            3'd4:    hdr_byte = 8'hCC;
            3'd5:    hdr_byte = 8'h13;
            3'd6:    hdr_byte = 8'h7D;
            default: hdr_byte = 8'h74;
        endcase
    endfunction

    state_t        state, state_d;
    logic          cas_p0, cas_p1, cas_p2;
    logic [CW-1:0] cnt;
    logic          tog_p2, edge_ok, half_s, half_l, tmo;
    logic [HW-1:0] hcnt, hcnt_d;
    logic [2:0]    hidx, hidx_d;
    logic [3:0]    bitn, bitn_d;
    logic [1:0]    bit_s, bs_d, bit_s_n;
    logic          bit_l, bl_d, bit_l_n;
    logic [7:0]    sh, sh_d;
    logic          bit_done, bit_val, frame_err;
    logic          q_req, ovf_set, busy, pending;
    logic [7:0]    q_byte;

    // Input synchroniser and half-period measurement
    always_ff @(posedge clk) begin
        if (reset) begin
            cas_p0 <= 1'b0;
            cas_p1 <= 1'b0;
            cas_p2 <= 1'b0;
            cnt    <= '0;
        end else begin
            cas_p0 <= cas_in;
            cas_p1 <= cas_p0;
            cas_p2 <= cas_p1;
            if (edge_ok)
                cnt <= '0;
            else if (ce_5m3 && cnt != MAX_W)
                cnt <= cnt + 1'b1;
        end
    end

    assign tog_p2  = cas_p1 ^ cas_p2;
    assign edge_ok = tog_p2 && (cnt >= MIN_W);
    assign half_s  = edge_ok && (cnt < THR_W);
    assign half_l  = edge_ok && !(cnt < THR_W);
    assign tmo     = (cnt == MAX_W) || !cas_motor;
    assign busy    = pending || ram_wr;

    // Bit assembly: two long halves make a 0, four short halves make a 1
    always_comb begin
        bit_done  = 1'b0;
        bit_val   = 1'b0;
        frame_err = 1'b0;
        bit_s_n   = bit_s;
        bit_l_n   = bit_l;
        if (half_s) begin
            if (bit_l) begin
                frame_err = 1'b1;
            end else if (bit_s == 2'd3) begin
                bit_done = 1'b1;
                bit_val  = 1'b1;
                bit_s_n  = 2'd0;
            end else begin
                bit_s_n = bit_s + 2'd1;
            end
        end else if (half_l) begin
            if (bit_s != 2'd0) begin
                frame_err = 1'b1;
            end else if (bit_l) begin
                bit_done = 1'b1;
                bit_l_n  = 1'b0;
            end else begin
                bit_l_n = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        hcnt_d  = hcnt;
        hidx_d  = hidx;
        bitn_d  = bitn;
        sh_d    = sh;
        bs_d    = bit_s;
        bl_d    = bit_l;
        q_req   = 1'b0;
        q_byte  = 8'h00;
        ovf_set = 1'b0;
        case (state)
            IDLE, WAIT_START: begin
                if (half_s) begin
                    if (hcnt == HDR_LAST) begin
                        state_d = PAD;
                        hcnt_d  = '0;
                        hidx_d  = 3'd0;
                    end else begin
                        hcnt_d = hcnt + 1'b1;
                    end
                end else if (half_l) begin
                    hcnt_d = '0;
                    if (state == WAIT_START) begin
                        state_d = DATA;
                        bl_d    = 1'b1;
                        bs_d    = 2'd0;
                        bitn_d  = 4'd0;
                    end
                end
            end
            PAD: begin
                if (!busy) begin
                    if (ram_a[2:0] != 3'd0) begin
                        q_req = 1'b1;
                    end else begin
                        state_d = HDR;
                        hidx_d  = 3'd0;
                    end
                end
            end
            HDR: begin
                if (!busy) begin
                    q_req  = 1'b1;
                    q_byte = hdr_byte(hidx);
                    hidx_d = hidx + 3'd1;
                    if (hidx == 3'd7) begin
                        state_d = WAIT_START;
                        hcnt_d  = '0;
                        bs_d    = 2'd0;
                        bl_d    = 1'b0;
                    end
                end
            end
            DATA: begin
                bs_d = bit_s_n;
                bl_d = bit_l_n;
                if (frame_err) begin
                    state_d = WAIT_START;
                    hcnt_d  = '0;
                    bs_d    = 2'd0;
                    bl_d    = 1'b0;
                end else if (bit_done) begin
                    // bitn 0 is the start bit; data bits arrive as bitn 1..8
                    if (bitn == 4'd0) begin
                        bitn_d = 4'd1;
                    end else begin
                        sh_d   = {bit_val, sh[7:1]};
                        bitn_d = bitn + 4'd1;
                        if (bitn == 4'd8)
                            state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (half_l) begin
                    state_d = WAIT_START;
                    hcnt_d  = '0;
                    bs_d    = 2'd0;
                    bl_d    = 1'b0;
                end else if (half_s) begin
                    bs_d = bit_s_n;
                    if (bit_done) begin
                        if (busy) begin
                            ovf_set = 1'b1;
                        end else begin
                            q_req  = 1'b1;
                            q_byte = sh;
                        end
                        state_d = WAIT_START;
                        hcnt_d  = '0;
                        bs_d    = 2'd0;
                        bl_d    = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Timeout aborts the frame but leaves any byte queued this cycle intact
        if (tmo) begin
            state_d = IDLE;
            hcnt_d  = '0;
            bs_d    = 2'd0;
            bl_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || rewind) begin
            state <= IDLE;
            hcnt  <= '0;
            hidx  <= 3'd0;
            bitn  <= 4'd0;
            bit_s <= 2'd0;
            bit_l <= 1'b0;
        end else begin
            state <= state_d;
            hcnt  <= hcnt_d;
            hidx  <= hidx_d;
            bitn  <= bitn_d;
            bit_s <= bs_d;
            bit_l <= bl_d;
        end
    end

    always_ff @(posedge clk) begin
        sh <= sh_d;
    end

    // Write port: one holding register, strobe then address advance
    always_ff @(posedge clk) begin
        if (reset || rewind) begin
            ram_a    <= '0;
            ram_do   <= 8'h00;
            ram_wr   <= 1'b0;
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            ram_wr <= 1'b0;
            if (ram_wr)
                ram_a <= ram_a + 27'd1;
            if (pending && buff_mem_ready) begin
                ram_wr  <= 1'b1;
                pending <= 1'b0;
            end
            if (q_req) begin
                ram_do  <= q_byte;
                pending <= 1'b1;
            end
            if (ovf_set)
                overflow <= 1'b1;
        end
    end

    assign recording = (state != IDLE);

endmodule

// File: tb/tb_tape_rec.sv
// Bench for tape_rec: scaled-down pulse timing, FSK stimulus generator and a
// write scoreboard fed by a small model of the .CAS block layout.
`timescale 1ns/1ps
module tb_tape_rec;

    localparam int MIN_P = 4;
    localparam int THR   = 16;
    localparam int MAX_P = 40;
    localparam int HMIN  = 16;
    localparam int S_W   = 11;
    localparam int L_W   = 22;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_5m3 = 1'b0;
    logic        cas_motor = 1'b1;
    logic        cas_in = 1'b0;
    logic        rewind = 1'b0;
    logic        buff_mem_ready = 1'b1;
    logic [26:0] ram_a;
    logic [7:0]  ram_do;
    logic        ram_wr;
    logic        overflow;
    logic        recording;

    tape_rec #(
        .MIN_PULSE(MIN_P),
        .THRESH(THR),
        .MAX_PULSE(MAX_P),
        .HDR_MIN(HMIN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ce_5m3(ce_5m3),
        .cas_motor(cas_motor),
        .cas_in(cas_in),
        .rewind(rewind),
        .ram_a(ram_a),
        .ram_do(ram_do),
        .ram_wr(ram_wr),
        .buff_mem_ready(buff_mem_ready),
        .overflow(overflow),
        .recording(recording)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1 ce_5m3 = ~ce_5m3;
        end
    end

    typedef struct {
        logic [26:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        logic [7:0] data;
        bit         glitch;
        bit         bad_stop;
        bit         wr;
    } vec_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [26:0] exp_a = '0;
    int          nchk = 0;
    int          npass = 0;
    logic [7:0]  hdr_tab[8];
    vec_t        vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act === req) npass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, req);
    endtask

    always @(negedge clk) begin
        if (!reset && ram_wr) begin
            if (exp_q.size() == 0) begin
                nchk++;
                $display("FAIL unexpected_write: got addr %0h data %0h, want no write", ram_a, ram_do);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", {5'd0, ram_a}, {5'd0, mon_e.a});
                chk("wr_data", {24'd0, ram_do}, {24'd0, mon_e.d});
            end
        end
    end

    task automatic push(input logic [7:0] d);
        wr_t e;
        e.a = exp_a;
        e.d = d;
        exp_q.push_back(e);
        exp_a = exp_a + 27'd1;
    endtask

    task automatic tick_wait(input int n);
        int i = 0;
        while (i < n) begin
            @(posedge clk);
            if (ce_5m3) i++;
        end
    endtask

    task automatic half(input int w);
        tick_wait(w);
        #1 cas_in = ~cas_in;
    endtask

    task automatic send_bit(input bit b, input bit gl);
        int w;
        w = b ? S_W : L_W;
        if (gl) begin
            tick_wait(1);
            #1 cas_in = ~cas_in;
            tick_wait(1);
            #1 cas_in = ~cas_in;
            half(w - 2);
        end else begin
            half(w);
        end
        half(w);
        if (b) begin
            half(w);
            half(w);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit gl, input bit bad_stop);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], gl && (i == 3));
        send_bit(!bad_stop, 1'b0);
        send_bit(1'b1, 1'b0);
    endtask

    task automatic send_header();
        while (exp_a[2:0] != 3'd0) push(8'h00);
        for (int i = 0; i < 8; i++) push(hdr_tab[i]);
        for (int i = 0; i < HMIN + 8; i++) half(S_W);
    endtask

    initial begin
        hdr_tab = '{8'h1F, 8'hA6, 8'hDE, 8'hBA, 8'hCC, 8'h13, 8'h7D, 8'h74};
        vecs[0] = '{data: 8'hA5, glitch: 1'b0, bad_stop: 1'b0, wr: 1'b1};
        vecs[1] = '{data: 8'h3C, glitch: 1'b1, bad_stop: 1'b0, wr: 1'b1};
        vecs[2] = '{data: 8'h5A, glitch: 1'b0, bad_stop: 1'b1, wr: 1'b0};
        vecs[3] = '{data: 8'h81, glitch: 1'b0, bad_stop: 1'b0, wr: 1'b1};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ram_a", {5'd0, ram_a}, 32'd0);
        chk("rst_ram_do", {24'd0, ram_do}, 32'd0);
        chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_recording", {31'd0, recording}, 32'd0);

        send_header();
        @(negedge clk);
        chk("hdr1_recording", {31'd0, recording}, 32'd1);
        chk("hdr1_ram_a", {5'd0, ram_a}, 32'd8);

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].wr) push(vecs[v].data);
            send_byte(vecs[v].data, vecs[v].glitch, vecs[v].bad_stop);
            @(negedge clk);
            chk("vec_ram_a", {5'd0, ram_a}, {5'd0, exp_a});
        end

        // Byte abandoned mid-frame by silence
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        tick_wait(MAX_P + 10);
        @(negedge clk);
        chk("tmo_recording", {31'd0, recording}, 32'd0);
        chk("tmo_ram_a", {5'd0, ram_a}, 32'd11);

        send_header();
        @(negedge clk);
        chk("hdr2_ram_a", {5'd0, ram_a}, 32'd24);
        chk("hdr2_recording", {31'd0, recording}, 32'd1);

        buff_mem_ready = 1'b0;
        push(8'hB1);
        send_byte(8'hB1, 1'b0, 1'b0);
        send_byte(8'hB2, 1'b0, 1'b0);
        @(negedge clk);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_held_ram_a", {5'd0, ram_a}, 32'd24);
        buff_mem_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("ovf_ram_a", {5'd0, ram_a}, 32'd25);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        buff_mem_ready = 1'b0;
        send_byte(8'hC7, 1'b0, 1'b0);
        @(posedge clk);
        #1 rewind = 1'b1;
        @(posedge clk);
        #1 rewind = 1'b0;
        buff_mem_ready = 1'b1;
        exp_a = '0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rew_ram_a", {5'd0, ram_a}, 32'd0);
        chk("rew_overflow", {31'd0, overflow}, 32'd0);
        chk("rew_recording", {31'd0, recording}, 32'd0);

        send_header();
        @(negedge clk);
        chk("hdr3_ram_a", {5'd0, ram_a}, 32'd8);

        cas_motor = 1'b0;
        repeat (2) @(negedge clk);
        chk("motor_off_recording", {31'd0, recording}, 32'd0);

        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
